execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the RV32 in-order single-issue pipeline, directly downstream of the register-file stage. Consumes `rv32_issue_packet_t`, resolves operand hazards by forwarding from its own EX/MEM output register and from the writeback packet, and computes the ALU result. It runs an iterative 32-cycle divider for DIV/DIVU/REM/REMU, stalling upstream while busy. Results land in a registered `rv32_ex2mem_packet_t` for the memory stage.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `DIV_CYCLES`, 32: divider iteration count. Must equal `XLEN`.
- `clk`  in  1: clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `issue_packet`  in  `rv32_issue_packet_t`: operands and control from the register-file stage.
- `writeback_packet`  in  `rv32_mem2wb_packet_t`: MEM/WB forwarding source (`wb_addr`, `wb_data`, `wb_enable`, `valid_opcode`).
- `flush`  in  1: synchronous pipeline flush, for example on a branch redirect.
- `stall`  out  1: upstream must hold `issue_packet` unchanged while high.
- `ex_packet`  out  `rv32_ex2mem_packet_t`: registered result. Fields: `alu_result`, `store_data`, `rd_sel`, `pc`, `valid_opcode`, `wb_enable`, `dont_forward`.

## Operation
- **Operand selection**, per rs1/rs2, highest priority first:
  - If `sel == 0`, the operand is 0 and no hazard is possible.
  - EX/MEM match: `ex_packet.valid_opcode && ex_packet.wb_enable && ex_packet.rd_sel == sel`. Use `alu_result`.
  - MEM/WB match: `writeback_packet.valid_opcode && wb_enable && wb_addr == sel`. Use `wb_data`.
  - Otherwise use the packet's `rsN_value`.
- **Load-use hazard.** An EX/MEM match with `ex_packet.dont_forward` set means the value is not yet available:
  - assert `stall` for that cycle;
  - write a bubble into `ex_packet` (`valid_opcode = 0`, `wb_enable = 0`).
- **Operand B.** Use `imm32` when `alu_op_uses_imm(alu_op)` is true, otherwise use forwarded rs2.
- **`store_data`** is always the forwarded rs2.
- **ALU.** ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, and LUI (pass `imm32`).
  - Shift amount is `opB[4:0]`.
  - All arithmetic is modulo 2^32.
- **Divider FSM**, states IDLE, BUSY, DONE. Restoring shift-subtract, one quotient bit per cycle. Signed ops divide magnitudes, then fix up signs.
  - IDLE → BUSY when `valid_opcode` is set, the op is a div op, there is no flush and no load-use hazard. Forwarded operands are latched at that edge.
  - BUSY: `count` goes 0..31; at `count == 31` → DONE.
  - DONE → IDLE unconditionally, and the result is written into `ex_packet` at that edge.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
- **`stall`** is high when either condition holds:
  - (IDLE and a valid div op is present) or BUSY;
  - a load-use hazard exists.
- While `stall` is high, `ex_packet` receives a bubble every cycle. The DONE cycle is the exception: `stall` is low and the div result is registered.
- **Flush**, which takes priority over everything:
  - at the next edge, `ex_packet` becomes a bubble and the FSM goes to IDLE;
  - combinationally, `stall` goes low in the flush cycle.
- **Pass-through fields.** `rd_sel`, `pc` and `dont_forward` come from `issue_packet`. `wb_enable` is `alu_op_writes_rd(alu_op) && valid_opcode`.

## Timing
- **Reset.**
  - `ex_packet` is all zeros; in particular `valid_opcode = 0` and `wb_enable = 0`.
  - FSM is IDLE, `count = 0`, and `stall = 0` (given no valid div op at the input).
- **Non-div ops.** One-cycle latency: inputs in cycle N, `ex_packet` valid after edge N+1.
- **Div ops.**
  - Issued in cycle 0: `stall` is high in cycles 0–32 (33 cycles) and low in cycle 33 (DONE).
  - The result is visible in `ex_packet` after edge 34.
  - Upstream advances at edge 34.
- **Load-use.** Exactly one bubble cycle. Next cycle the producer is in MEM/WB and forwarding takes the `wb_data` path.
- **Back-to-back div.** A second div arriving in the cycle right after DONE enters BUSY with no idle gap.
- **Reset mid-division.** Asynchronous: the FSM is forced to IDLE immediately and the partial result is discarded.
- **Flush during BUSY.** The divider aborts and no result is written.
- **Same-cycle EX/MEM and MEM/WB match on one register.** EX/MEM wins.

## Structure
- Add to `rv32_pkg`:
  - `rv32_ex2mem_packet_t`;
  - `rv32_alu_op_t` enum entries DIV, DIVU, REM, REMU;
  - functions `alu_op_uses_imm`, `alu_op_writes_rd`, `alu_op_is_div`;
  - `div_state_t` enum (IDLE, BUSY, DONE).
- One sub-module, `rv32_iter_divider`. Ports: clk, resetn, start, abort, signed_op, rem_op, dividend, divisor, busy, done, result. It owns the FSM and counter.
- Forwarding mux, ALU and output register live in `execute_stage`.

## Test plan
- ADD x3,x1,x2 with x1=5, x2=7, no hazards → after 1 edge, `alu_result` = 12, `rd_sel` = 3, `wb_enable` = 1.
- Forwarding priority: EX/MEM writes x1 = 0x10, MEM/WB writes x1 = 0x20, then SUB x4,x1,x0 → `alu_result` = 0x10. Repeat with rs = x0 and the producer writing x0 → operand is 0.
- Load-use: `ex_packet` has `dont_forward = 1`, `rd = 5`; next op reads x5 → `stall` for 1 cycle, one bubble, then the op uses `wb_data`.
- DIV 0xFFFFFFF9 / 2 (−7/2) → quotient 0xFFFFFFFD, `stall` high exactly 33 cycles. REM same operands → 0xFFFFFFFF.
- Divide by zero: DIVU 100/0 → 0xFFFFFFFF; REMU → 100. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush at BUSY count 10 → the next `ex_packet` is a bubble, the FSM is IDLE, `stall` is low. Then assert `resetn` low mid-division → all outputs zero asynchronously.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 pipeline packet types, ALU op encoding and decode helpers
package rv32_pkg;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_ADDI, ALU_ANDI, ALU_ORI,
        ALU_XORI, ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_SLTI, ALU_SLTIU, ALU_STORE,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } rv32_alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  rs1_value;
        logic [31:0]  rs2_value;
        logic [31:0]  imm32;
        logic [4:0]   rs1_sel;
        logic [4:0]   rs2_sel;
        logic [4:0]   rd_sel;
        rv32_alu_op_t alu_op;
        logic         valid_opcode;
        logic         dont_forward;
    } rv32_issue_packet_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  wb_addr;
        logic        wb_enable;
        logic        valid_opcode;
    } rv32_mem2wb_packet_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic [4:0]  rd_sel;
        logic        valid_opcode;
        logic        wb_enable;
        logic        dont_forward;
    } rv32_ex2mem_packet_t;

    function automatic logic alu_op_uses_imm(input rv32_alu_op_t op);
        return op inside {ALU_LUI, ALU_ADDI, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_SLLI,
                          ALU_SRLI, ALU_SRAI, ALU_SLTI, ALU_SLTIU, ALU_STORE};
    endfunction

    function automatic logic alu_op_writes_rd(input rv32_alu_op_t op);
        return !(op inside {ALU_NOP, ALU_STORE});
    endfunction

    function automatic logic alu_op_is_div(input rv32_alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/rv32_iter_divider.sv
// rtl/rv32_iter_divider.sv - iterative restoring divider, one quotient bit per cycle
module rv32_iter_divider
    import rv32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            abort,
    input  logic            signed_op,
    input  logic            rem_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_quot, r_rem, r_divisor;
    logic             r_neg_q, r_neg_r, r_rem_op;
    logic [XLEN-1:0]  w_abs_a, w_abs_b;
    logic [XLEN:0]    w_shift;
    logic             w_ge;

    assign w_abs_a = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
    assign w_abs_b = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_divisor};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = BUSY;
            BUSY:    if (r_count == CNT_W'(DIV_CYCLES - 1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (abort) w_state_next = IDLE;
    end

    // A zero divisor leaves the quotient unsigned all-ones and the remainder equal to the dividend
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_op  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_count   <= '0;
            r_quot    <= w_abs_a;
            r_rem     <= '0;
            r_divisor <= w_abs_b;
            r_neg_q   <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]) && (divisor != '0);
            r_neg_r   <= signed_op && dividend[XLEN-1];
            r_rem_op  <= rem_op;
        end else if (r_state == BUSY) begin
            r_count <= r_count + 1'b1;
            r_quot  <= {r_quot[XLEN-2:0], w_ge};
            r_rem   <= w_ge ? (w_shift[XLEN-1:0] - r_divisor) : w_shift[XLEN-1:0];
        end
    end

    assign busy   = (r_state == BUSY);
    assign done   = (r_state == DONE);
    assign result = r_rem_op ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quot : r_quot);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32 execute stage: operand forwarding, ALU, divider control, EX/MEM register
module execute_stage
    import rv32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  rv32_issue_packet_t  issue_packet,
    input  rv32_mem2wb_packet_t writeback_packet,
    input  logic                flush,
    output logic                stall,
    output rv32_ex2mem_packet_t ex_packet
);
    rv32_ex2mem_packet_t r_ex, w_ex_next;
    logic                w_ex1, w_ex2, w_wb1, w_wb2, w_load_use, w_is_div, w_start;
    logic                w_div_busy, w_div_done, w_div_idle;
    logic [XLEN-1:0]     w_rs1, w_rs2, w_op_b, w_alu, w_div_result;
    logic [4:0]          w_shamt;

    assign w_ex1 = (issue_packet.rs1_sel != '0) && r_ex.valid_opcode && r_ex.wb_enable
                   && (r_ex.rd_sel == issue_packet.rs1_sel);
    assign w_ex2 = (issue_packet.rs2_sel != '0) && r_ex.valid_opcode && r_ex.wb_enable
                   && (r_ex.rd_sel == issue_packet.rs2_sel);
    assign w_wb1 = (issue_packet.rs1_sel != '0) && writeback_packet.valid_opcode
                   && writeback_packet.wb_enable && (writeback_packet.wb_addr == issue_packet.rs1_sel);
    assign w_wb2 = (issue_packet.rs2_sel != '0) && writeback_packet.valid_opcode
                   && writeback_packet.wb_enable && (writeback_packet.wb_addr == issue_packet.rs2_sel);

    assign w_rs1 = (issue_packet.rs1_sel == '0) ? '0 : w_ex1 ? r_ex.alu_result
                 : w_wb1 ? writeback_packet.wb_data : issue_packet.rs1_value;
    assign w_rs2 = (issue_packet.rs2_sel == '0) ? '0 : w_ex2 ? r_ex.alu_result
                 : w_wb2 ? writeback_packet.wb_data : issue_packet.rs2_value;
    assign w_op_b  = alu_op_uses_imm(issue_packet.alu_op) ? issue_packet.imm32 : w_rs2;
    assign w_shamt = w_op_b[4:0];

    // A producer still in EX/MEM marked dont_forward has no data yet
    assign w_load_use = issue_packet.valid_opcode && r_ex.dont_forward && (w_ex1 || w_ex2);
    assign w_is_div   = issue_packet.valid_opcode && alu_op_is_div(issue_packet.alu_op);
    assign w_div_idle = !w_div_busy && !w_div_done;
    assign w_start    = w_div_idle && w_is_div && !flush && !w_load_use;
    assign stall      = !flush && ((w_div_idle && w_is_div) || w_div_busy || w_load_use);

    always_comb begin
        w_alu = '0;
        case (issue_packet.alu_op)
            ALU_ADD, ALU_ADDI, ALU_STORE: w_alu = w_rs1 + w_op_b;
            ALU_SUB:                      w_alu = w_rs1 - w_op_b;
            ALU_AND, ALU_ANDI:            w_alu = w_rs1 & w_op_b;
            ALU_OR, ALU_ORI:              w_alu = w_rs1 | w_op_b;
            ALU_XOR, ALU_XORI:            w_alu = w_rs1 ^ w_op_b;
            ALU_SLL, ALU_SLLI:            w_alu = w_rs1 << w_shamt;
            ALU_SRL, ALU_SRLI:            w_alu = w_rs1 >> w_shamt;
            ALU_SRA, ALU_SRAI:            w_alu = $unsigned($signed(w_rs1) >>> w_shamt);
            ALU_SLT, ALU_SLTI:            w_alu = {{(XLEN-1){1'b0}}, $signed(w_rs1) < $signed(w_op_b)};
            ALU_SLTU, ALU_SLTIU:          w_alu = {{(XLEN-1){1'b0}}, w_rs1 < w_op_b};
            ALU_LUI:                      w_alu = issue_packet.imm32;
            default:                      w_alu = '0;
        endcase
    end

    rv32_iter_divider #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_start),
        .abort     (flush),
        .signed_op (issue_packet.alu_op inside {ALU_DIV, ALU_REM}),
        .rem_op    (issue_packet.alu_op inside {ALU_REM, ALU_REMU}),
        .dividend  (w_rs1),
        .divisor   (w_rs2),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .result    (w_div_result)
    );

    // The DONE cycle has stall low, so the held div op retires with the divider result
    always_comb begin
        w_ex_next              = '0;
        w_ex_next.alu_result   = w_div_done ? w_div_result : w_alu;
        w_ex_next.store_data   = w_rs2;
        w_ex_next.pc           = issue_packet.pc;
        w_ex_next.rd_sel       = issue_packet.rd_sel;
        w_ex_next.valid_opcode = issue_packet.valid_opcode;
        w_ex_next.wb_enable    = issue_packet.valid_opcode && alu_op_writes_rd(issue_packet.alu_op);
        w_ex_next.dont_forward = issue_packet.dont_forward;
        if (flush || stall) w_ex_next = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ex <= '0;
        else         r_ex <= w_ex_next;
    end

    assign ex_packet = r_ex;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed and randomized self-checking bench for execute_stage
module tb_execute_stage;
    import rv32_pkg::*;

    logic                clk = 1'b0;
    logic                resetn;
    logic                flush;
    logic                stall;
    rv32_issue_packet_t  ip;
    rv32_mem2wb_packet_t wp;
    rv32_ex2mem_packet_t ep;
    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic [31:0]         pc_ctr  = 32'h1000;

    rv32_alu_op_t alu_ops [21] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                                   ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_ADDI, ALU_ANDI, ALU_ORI,
                                   ALU_XORI, ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_SLTI, ALU_SLTIU, ALU_STORE};
    rv32_alu_op_t div_ops [4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .DIV_CYCLES(32)) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .issue_packet     (ip),
        .writeback_packet (wp),
        .flush            (flush),
        .stall            (stall),
        .ex_packet        (ep)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input rv32_alu_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic df);
        ip              = '0;
        ip.valid_opcode = 1'b1;
        ip.alu_op       = op;
        ip.rd_sel       = rd;
        ip.rs1_sel      = rs1;
        ip.rs2_sel      = rs2;
        ip.rs1_value    = v1;
        ip.rs2_value    = v2;
        ip.imm32        = imm;
        ip.dont_forward = df;
        ip.pc           = pc_ctr;
        pc_ctr          = pc_ctr + 32'd4;
    endtask

    function automatic logic [31:0] ref_div(input rv32_alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic want_q;
        logic sgn;
        want_q = (op == ALU_DIV) || (op == ALU_DIVU);
        sgn    = (op == ALU_DIV) || (op == ALU_REM);
        if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
        case (op)
            ALU_DIV:  return $signed(a) / $signed(b);
            ALU_REM:  return $signed(a) % $signed(b);
            ALU_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input rv32_alu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        case (op)
            ALU_ADD:   return a + b;
            ALU_ADDI:  return a + imm;
            ALU_STORE: return a + imm;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_ANDI:  return a & imm;
            ALU_OR:    return a | b;
            ALU_ORI:   return a | imm;
            ALU_XOR:   return a ^ b;
            ALU_XORI:  return a ^ imm;
            ALU_SLL:   return a << b[4:0];
            ALU_SLLI:  return a << imm[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRLI:  return a >> imm[4:0];
            ALU_SRA:   return $signed(a) >>> b[4:0];
            ALU_SRAI:  return $signed(a) >>> imm[4:0];
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTI:  return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_SLTIU: return (a < imm) ? 32'd1 : 32'd0;
            ALU_LUI:   return imm;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] sel, input logic [31:0] rf,
                                                input logic ex_wr, input logic [4:0] ex_rd,
                                                input logic [31:0] ex_val, input rv32_mem2wb_packet_t w);
        if (sel == 5'd0) return 32'd0;
        if (ex_wr && ex_rd == sel) return ex_val;
        if (w.valid_opcode && w.wb_enable && w.wb_addr == sel) return w.wb_data;
        return rf;
    endfunction

    task automatic run_div(input string tag, input rv32_alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] exp;
        exp = ref_div(op, a, b);
        wp  = '0;
        set_op(op, 5'd9, 5'd1, 5'd2, a, b, 32'd0, 1'b0);
        n = 0;
        #1;
        while (stall && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        step();
        check({tag, "_result"}, ep.alu_result, exp);
        check({tag, "_valid"}, 32'(ep.valid_opcode), 32'd1);
    endtask

    initial begin
        rv32_alu_op_t op;
        logic [4:0]   rd, s1, s2;
        logic [31:0]  v1, v2, imm, a, b, exp;
        logic         m_wr;
        logic [4:0]   m_rd;
        logic [31:0]  m_val;

        resetn = 1'b0;
        flush  = 1'b0;
        ip     = '0;
        wp     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ep.valid_opcode), 32'd0);
        check("rst_wb_en", 32'(ep.wb_enable), 32'd0);
        check("rst_result", ep.alu_result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        resetn = 1'b1;
        step();

        set_op(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0);
        #1;
        check("add_stall", 32'(stall), 32'd0);
        step();
        check("add_result", ep.alu_result, 32'd12);
        check("add_rd", 32'(ep.rd_sel), 32'd3);
        check("add_wb_en", 32'(ep.wb_enable), 32'd1);
        check("add_pc", ep.pc, 32'h1000);

        set_op(ALU_ADDI, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10, 1'b0);
        step();
        set_op(ALU_SUB, 5'd4, 5'd1, 5'd0, 32'hDEAD, 32'd0, 32'd0, 1'b0);
        wp = '{wb_data: 32'h20, wb_addr: 5'd1, wb_enable: 1'b1, valid_opcode: 1'b1};
        step();
        check("fwd_ex_priority", ep.alu_result, 32'h10);
        set_op(ALU_ADD, 5'd6, 5'd1, 5'd0, 32'hDEAD, 32'd0, 32'd0, 1'b0);
        step();
        check("fwd_wb_path", ep.alu_result, 32'h20);

        set_op(ALU_ADDI, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h55, 1'b0);
        wp = '{wb_data: 32'h66, wb_addr: 5'd0, wb_enable: 1'b1, valid_opcode: 1'b1};
        step();
        set_op(ALU_SUB, 5'd4, 5'd0, 5'd0, 32'h1234, 32'h99, 32'd0, 1'b0);
        step();
        check("fwd_x0_zero", ep.alu_result, 32'd0);

        wp = '0;
        set_op(ALU_ADDI, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 32'hBAD, 1'b1);
        step();
        check("lu_producer_df", 32'(ep.dont_forward), 32'd1);
        set_op(ALU_ADD, 5'd8, 5'd5, 5'd0, 32'h111, 32'd0, 32'd0, 1'b0);
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        step();
        check("lu_bubble_valid", 32'(ep.valid_opcode), 32'd0);
        check("lu_bubble_wb_en", 32'(ep.wb_enable), 32'd0);
        wp = '{wb_data: 32'h77, wb_addr: 5'd5, wb_enable: 1'b1, valid_opcode: 1'b1};
        #1;
        check("lu_stall_clear", 32'(stall), 32'd0);
        step();
        check("lu_result_wb", ep.alu_result, 32'h77);
        check("lu_valid", 32'(ep.valid_opcode), 32'd1);

        ip = '0;
        wp = '0;
        step();
        m_wr  = 1'b0;
        m_rd  = 5'd0;
        m_val = 32'd0;
        for (int i = 0; i < 40; i++) begin
            op  = alu_ops[$urandom_range(0, 20)];
            rd  = 5'($urandom_range(0, 3));
            s1  = 5'($urandom_range(0, 3));
            s2  = 5'($urandom_range(0, 3));
            v1  = $urandom;
            v2  = $urandom;
            imm = $urandom;
            wp.valid_opcode = 1'($urandom_range(0, 1));
            wp.wb_enable    = 1'($urandom_range(0, 1));
            wp.wb_addr      = 5'($urandom_range(0, 3));
            wp.wb_data      = $urandom;
            a   = ref_operand(s1, v1, m_wr, m_rd, m_val, wp);
            b   = ref_operand(s2, v2, m_wr, m_rd, m_val, wp);
            exp = ref_alu(op, a, b, imm);
            set_op(op, rd, s1, s2, v1, v2, imm, 1'b0);
            step();
            check($sformatf("rand_alu_%0d_%s", i, op.name()), ep.alu_result, exp);
            check($sformatf("rand_store_data_%0d", i), ep.store_data, b);
            check($sformatf("rand_wb_en_%0d", i), 32'(ep.wb_enable), 32'(op != ALU_STORE));
            m_wr  = (op != ALU_STORE);
            m_rd  = rd;
            m_val = exp;
        end

        ip = '0;
        wp = '0;
        step();
        run_div("div_neg7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_div("rem_neg7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_by0", ALU_DIVU, 32'd100, 32'd0);
        run_div("remu_by0", ALU_REMU, 32'd100, 32'd0);
        run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run_div($sformatf("rand_div_%0d", i), div_ops[$urandom_range(0, 3)], a, b);
        end

        set_op(ALU_DIV, 5'd9, 5'd1, 5'd2, 32'd1000, 32'd7, 32'd0, 1'b0);
        repeat (11) step();
        check("flush_pre_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        ip    = '0;
        #1;
        check("flush_stall_low", 32'(stall), 32'd0);
        step();
        flush = 1'b0;
        check("flush_bubble", 32'(ep.valid_opcode), 32'd0);
        #1;
        check("flush_idle_stall", 32'(stall), 32'd0);
        repeat (40) step();
        check("flush_no_late_result", 32'(ep.valid_opcode), 32'd0);
        run_div("div_after_flush", ALU_DIVU, 32'd1000, 32'd7);

        set_op(ALU_DIVU, 5'd9, 5'd1, 5'd2, 32'd1000, 32'd7, 32'd0, 1'b0);
        repeat (5) step();
        ip = '0;
        #2;
        resetn = 1'b0;
        #1;
        check("rstdiv_stall", 32'(stall), 32'd0);
        check("rstdiv_valid", 32'(ep.valid_opcode), 32'd0);
        step();
        resetn = 1'b1;
        step();
        repeat (40) step();
        check("rstdiv_no_late_result", 32'(ep.valid_opcode), 32'd0);
        run_div("remu_after_reset", ALU_REMU, 32'd1000, 32'd7);

        set_op(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0);
        step();
        check("async_pre_result", ep.alu_result, 32'd12);
        ip = '0;
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_result", ep.alu_result, 32'd0);
        check("async_rst_valid", 32'(ep.valid_opcode), 32'd0);
        check("async_rst_rd", 32'(ep.rd_sel), 32'd0);
        step();
        resetn = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
